ascii_time_parser: RTL and testbench

//  Receive-side decoder for the ASCII time frame "CL HH:MM:SS\n" / "SW HH:MM:SS\n".

---
 rtl/ascii_time_parser.sv | 137 +++++++++++++
 tb/tb_ascii_time_parser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ascii_time_parser.sv
// Receive-side decoder for "CL HH:MM:SS\n" / "SW HH:MM:SS\n" time frames.
// A good frame preloads BCD digits and the mode bit; a bad or stalled frame is flagged.
module ascii_time_parser #(
    parameter int DATA_WIDTH    = 8,
    parameter int HOUR          = 24,
    parameter int TIMEOUT_TICKS = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_100hz,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [3:0]            hour1,
    output logic [3:0]            hour0,
    output logic [3:0]            min1,
    output logic [3:0]            min0,
    output logic [3:0]            sec1,
    output logic [3:0]            sec0,
    output logic                  set_mode,
    output logic                  set_valid,
    output logic                  frame_err
);
    // Declaration order matters: a good byte advances to the next enumerator.
    typedef enum logic [3:0] {
        IDLE, P1, P2, H1, H0, C1, M1, M0, C2, S1, S0, NL, RESYNC
    } state_t;

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [DATA_WIDTH-1:0] CH_CR  = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CH_LF  = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CH_SP  = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] CH_COL = DATA_WIDTH'(8'h3A);
    localparam logic [DATA_WIDTH-1:0] CH_0   = DATA_WIDTH'(8'h30);
    localparam logic [DATA_WIDTH-1:0] CH_5   = DATA_WIDTH'(8'h35);
    localparam logic [DATA_WIDTH-1:0] CH_9   = DATA_WIDTH'(8'h39);
    localparam logic [DATA_WIDTH-1:0] CH_C   = DATA_WIDTH'(8'h43);
    localparam logic [DATA_WIDTH-1:0] CH_L   = DATA_WIDTH'(8'h4C);
    localparam logic [DATA_WIDTH-1:0] CH_S   = DATA_WIDTH'(8'h53);
    localparam logic [DATA_WIDTH-1:0] CH_W   = DATA_WIDTH'(8'h57);
    localparam logic [DATA_WIDTH-1:0] H1_MAX = DATA_WIDTH'(48 + (HOUR - 1) / 10);
    localparam logic [7:0]            HOUR_LIM = 8'(HOUR - 1);

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic [3:0]      h1_sh, h0_sh, m1_sh, m0_sh, s1_sh, s0_sh;
    logic            mode_sh;
    logic            byte_in, byte_ok, timeout, valid_nxt, err_nxt, hour_ok;
    logic [3:0]      dig;
    logic [7:0]      hour_val;

    function automatic logic in_rng(input logic [DATA_WIDTH-1:0] b,
                                    input logic [DATA_WIDTH-1:0] lo,
                                    input logic [DATA_WIDTH-1:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

    // CR is invisible: it neither advances the FSM nor restarts the timer.
    assign byte_in  = rx_valid && (rx_data != CH_CR);
    assign dig      = 4'(rx_data - CH_0);
    assign hour_val = 8'(h1_sh) * 8'd10 + 8'(dig);
    assign hour_ok  = hour_val <= HOUR_LIM;
    assign timeout  = (state != IDLE) && tick_100hz && !byte_in && (timer == TIMER_LAST);

    always_comb begin
        state_nxt = state;
        byte_ok   = 1'b0;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE:    byte_ok = (rx_data == CH_C) || (rx_data == CH_S);
            P1:      byte_ok = rx_data == (mode_sh ? CH_L : CH_W);
            P2:      byte_ok = rx_data == CH_SP;
            H1:      byte_ok = in_rng(rx_data, CH_0, H1_MAX);
            H0:      byte_ok = in_rng(rx_data, CH_0, CH_9) && hour_ok;
            C1, C2:  byte_ok = rx_data == CH_COL;
            M1, S1:  byte_ok = in_rng(rx_data, CH_0, CH_5);
            M0, S0:  byte_ok = in_rng(rx_data, CH_0, CH_9);
            NL:      byte_ok = rx_data == CH_LF;
            default: byte_ok = 1'b0;
        endcase
        if (byte_in) begin
            if (state == RESYNC) begin
                if (rx_data == CH_LF) state_nxt = IDLE;
            end else if (byte_ok) begin
                state_nxt = (state == NL) ? IDLE : state_t'(state + 4'd1);
                valid_nxt = state == NL;
            end else if (state != IDLE) begin
                err_nxt   = 1'b1;
                state_nxt = (rx_data == CH_LF) ? IDLE : RESYNC;
            end
        end else if (timeout) begin
            state_nxt = IDLE;
            err_nxt   = state != RESYNC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            set_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            set_valid <= valid_nxt;
            frame_err <= err_nxt;
            if (state_nxt == IDLE || byte_in) timer <= '0;
            else if (tick_100hz)              timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {h1_sh, h0_sh, m1_sh, m0_sh, s1_sh, s0_sh} <= '0;
            {hour1, hour0, min1, min0, sec1, sec0}     <= '0;
            mode_sh  <= 1'b0;
            set_mode <= 1'b0;
        end else if (byte_in && byte_ok) begin
            case (state)
                IDLE: mode_sh <= rx_data == CH_C;
                H1:   h1_sh   <= dig;
                H0:   h0_sh   <= dig;
                M1:   m1_sh   <= dig;
                M0:   m0_sh   <= dig;
                S1:   s1_sh   <= dig;
                S0:   s0_sh   <= dig;
                NL: begin
                    {hour1, hour0, min1, min0, sec1, sec0} <=
                        {h1_sh, h0_sh, m1_sh, m0_sh, s1_sh, s0_sh};
                    set_mode <= mode_sh;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_time_parser.sv
// Directed bench for ascii_time_parser; expected frame results are queued at stimulus
// time and popped whenever set_valid or frame_err pulses.
module tb_ascii_time_parser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_100hz = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] hour1, hour0, min1, min0, sec1, sec0;
    logic       set_mode, set_valid, frame_err;

    typedef struct packed {
        logic        is_err;
        logic [23:0] digits;
        logic        mode;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] last_digits = '0;
    logic        last_mode = 1'b0;
    int          checks = 0;
    int          errors = 0;

    ascii_time_parser #(.DATA_WIDTH(8), .HOUR(24), .TIMEOUT_TICKS(100)) dut (
        .clk(clk), .rst(rst), .tick_100hz(tick_100hz), .rx_data(rx_data),
        .rx_valid(rx_valid), .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0),
        .sec1(sec1), .sec0(sec0), .set_mode(set_mode), .set_valid(set_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_good(input logic [23:0] d, input logic m);
        exp_q.push_back('{is_err: 1'b0, digits: d, mode: m});
        last_digits = d;
        last_mode   = m;
    endtask

    task automatic push_err();
        exp_q.push_back('{is_err: 1'b1, digits: last_digits, mode: last_mode});
    endtask

    // Called at posedge+1; any pulse seen here must match the head of the queue.
    task automatic sample();
        exp_t e;
        if (set_valid || frame_err) begin
            checks++;
            assert (!(set_valid && frame_err)) else begin
                errors++;
                $error("FAIL both_pulses observed=1 expected=0");
            end
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse valid=%0b err=%0b expected=none", set_valid, frame_err);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pulse_kind", {23'd0, frame_err}, {23'd0, e.is_err});
                chk("digits", {hour1, hour0, min1, min0, sec1, sec0}, e.digits);
                chk("set_mode", {23'd0, set_mode}, {23'd0, e.mode});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_tick);
        rx_data    = b;
        rx_valid   = 1'b1;
        tick_100hz = with_tick;
        @(posedge clk); #1;
        rx_valid   = 1'b0;
        tick_100hz = 1'b0;
        sample();
        @(posedge clk); #1;
        sample();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_100hz = 1'b1;
            @(posedge clk); #1;
            tick_100hz = 1'b0;
            sample();
            @(posedge clk); #1;
            sample();
        end
    endtask

    task automatic pending(input string tag, input int n);
        chk(tag, 24'(exp_q.size()), 24'(n));
    endtask

    initial begin
        #12;
        chk("reset_digits", {hour1, hour0, min1, min0, sec1, sec0}, 24'h0);
        chk("reset_mode", {23'd0, set_mode}, 24'h0);
        chk("reset_pulses", {22'd0, set_valid, frame_err}, 24'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        push_good(24'h235958, 1'b1);
        send_str("CL 23:59:5");
        pending("cl_before_nl", 1);
        send_str("8\n");
        pending("cl_done", 0);

        push_good(24'h000107, 1'b0);
        send_str("SW 00:01:07\r");
        pending("sw_cr_ignored", 1);
        send_str("\n");
        pending("sw_done", 0);

        push_err();
        send_str("CL 2");
        pending("hour24_before", 1);
        send_str("4");
        pending("hour24_err", 0);
        send_str("00:00\n");

        push_good(24'h120000, 1'b1);
        send_str("CL 12:00:00\n");
        pending("after_resync", 0);

        push_err();
        send_str("S");
        pending("sl_before", 1);
        send_str("L");
        pending("sl_err", 0);
        send_str(" 10:00:00\n");

        push_err();
        send_str("CL 10:");
        pending("min6_before", 1);
        send_str("6");
        pending("min6_err", 0);
        send_str("\n");

        push_err();
        send_str("CL 10:");
        ticks(99);
        pending("timeout_99", 1);
        ticks(1);
        pending("timeout_100", 0);
        push_good(24'h191817, 1'b0);
        send_str("SW 19:18:17\n");
        pending("after_timeout", 0);

        push_err();
        send_str("CL 10");
        pending("early_nl_before", 1);
        send_str("\n");
        pending("early_nl_err", 0);
        push_good(24'h053015, 1'b0);
        send_str("SW 05:30:15\n");
        pending("early_nl_idle", 0);

        push_good(24'h103000, 1'b1);
        send_str("CL 10:");
        ticks(99);
        send_byte(8'h33, 1'b1);
        ticks(99);
        pending("byte_beats_tick", 1);
        send_str("0:00\n");
        pending("byte_tick_done", 0);

        send_str("CL 1");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_digits", {hour1, hour0, min1, min0, sec1, sec0}, 24'h0);
        chk("rst_mode", {23'd0, set_mode}, 24'h0);
        rst = 1'b0;
        last_digits = '0;
        last_mode   = 1'b0;
        @(posedge clk); #1;
        push_good(24'h080706, 1'b1);
        send_str("CL 08:07:06\n");

        repeat (4) begin
            @(posedge clk); #1;
            sample();
        end
        pending("final_queue", 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
